// File: rtl/stopwatch_pkg.sv
// Shared definitions for the serial BCD preset path.
//   rx_state_t     : receiver FSM state encoding
//   ASCII_*        : byte values recognised by the digit parser
//   clks_per_bit() : clock cycles per serial bit (integer division)
package stopwatch_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ESC  = 8'h1B;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Serial byte receiver: 2-flop synchroniser followed by the RX FSM.
// Frame is 8N1 by default, 8E1 when UART_PARITY_EN is defined.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   usb_rx         : asynchronous serial input, idle high
//   rx_byte        : last received byte (valid while byte_valid is high)
//   byte_valid     : one-cycle pulse, good frame received
//   framing_error  : one-cycle pulse, stop bit sampled low
//   parity_error   : one-cycle pulse, parity mismatch (0 without UART_PARITY_EN)
module uart_rx_byte
  import stopwatch_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       usb_rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       framing_error,
  output logic       parity_error
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);

  logic rx_meta, rx_s, rx_prev;

  rx_state_t         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              valid_d, ferr_d, perr_d;
`ifdef UART_PARITY_EN
  logic              par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      RX_IDLE: begin
        tick_d = '0;
        // Only a falling edge starts a frame; a line stuck low is ignored.
        if (rx_prev && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (tick_q == TICK_HALF) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          par_d   = rx_s;
          state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          state_d = RX_IDLE;
          if (!rx_s) begin
            ferr_d = 1'b1;
`ifdef UART_PARITY_EN
          end else if ((^shift_q) ^ par_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      rx_prev       <= 1'b1;
      state_q       <= RX_IDLE;
      tick_q        <= '0;
      bit_q         <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
    end else begin
      rx_meta       <= usb_rx;
      rx_s          <= rx_meta;
      rx_prev       <= rx_s;
      state_q       <= state_d;
      tick_q        <= tick_d;
      bit_q         <= bit_d;
      byte_valid    <= valid_d;
      framing_error <= ferr_d;
      parity_error  <= perr_d;
    end
  end

  // Shift data carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign rx_byte = shift_q;

endmodule

// File: rtl/uart_bcd_loader.sv
// Serial-to-BCD preset loader. ASCII digits received on usb_rx are shifted
// into a BCD buffer; CR or LF commits the buffer to number with a one-cycle
// load pulse, ESC discards it. Optional macro: UART_PARITY_EN (8E1 frames).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   usb_rx         : asynchronous serial input, idle high
//   number         : committed BCD value, most significant digit on top
//   load           : one-cycle pulse, number valid in the same cycle
//   digit_count    : digits buffered but not yet committed
//   framing_error  : one-cycle pulse, stop bit sampled low
//   parity_error   : one-cycle pulse, parity mismatch (0 without UART_PARITY_EN)
module uart_bcd_loader
  import stopwatch_pkg::*;
#(
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int BAUD_RATE                   = 115_200,
  parameter int NUMBER_OF_DIGITS            = 4,
  parameter int NUMBER_OF_BITS_PER_DIGIT    = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 usb_rx,
  output logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
  output logic                                                 load,
  output logic [$clog2(NUMBER_OF_DIGITS+1)-1:0]                digit_count,
  output logic                                                 framing_error,
  output logic                                                 parity_error
);

  localparam int CLKS_PER_BIT = clks_per_bit(BOARD_CLOCK_FREQUENCY_IN_HZ, BAUD_RATE);
  localparam int DW           = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
  localparam int CW           = $clog2(NUMBER_OF_DIGITS + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(NUMBER_OF_DIGITS);

  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic [DW-1:0] buffer;
  logic          is_digit, is_term, is_esc;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk           (clk),
    .rst           (rst),
    .usb_rx        (usb_rx),
    .rx_byte       (rx_byte),
    .byte_valid    (byte_valid),
    .framing_error (framing_error),
    .parity_error  (parity_error)
  );

  always_comb begin
    is_digit = (rx_byte >= ASCII_ZERO) && (rx_byte <= ASCII_NINE);
    is_term  = (rx_byte == ASCII_CR) || (rx_byte == ASCII_LF);
    is_esc   = (rx_byte == ASCII_ESC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      number      <= '0;
      load        <= 1'b0;
      buffer      <= '0;
      digit_count <= '0;
    end else begin
      load <= 1'b0;
      if (byte_valid) begin
        if (is_digit) begin
          // Low nibble of '0'..'9' is the digit value; the oldest digit
          // falls off the top when the buffer is already full.
          buffer <= (buffer << NUMBER_OF_BITS_PER_DIGIT) | DW'(rx_byte[3:0]);
          if (digit_count != COUNT_MAX) digit_count <= digit_count + 1'b1;
        end else if (is_term) begin
          // An empty buffer ignores the terminator, so CRLF loads once.
          if (digit_count != '0) begin
            number      <= buffer;
            load        <= 1'b1;
            buffer      <= '0;
            digit_count <= '0;
          end
        end else if (is_esc) begin
          buffer      <= '0;
          digit_count <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_bcd_loader.sv
module tb_uart_bcd_loader;

  localparam int CPB = 10;
  localparam int D   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        usb_rx = 1'b1;
  logic [15:0] number;
  logic        load;
  logic [2:0]  digit_count;
  logic        framing_error;
  logic        parity_error;

  always #5 clk = ~clk;

  uart_bcd_loader #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ (1_000_000),
    .BAUD_RATE                   (100_000),
    .NUMBER_OF_DIGITS            (4),
    .NUMBER_OF_BITS_PER_DIGIT    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .usb_rx        (usb_rx),
    .number        (number),
    .load          (load),
    .digit_count   (digit_count),
    .framing_error (framing_error),
    .parity_error  (parity_error)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending digits as a plain list, expected loads as a queue.
  int          model_digits[$];
  logic [15:0] exp_q[$];
  int          exp_ferr = 0;
  int          seen_ferr = 0;
  int          exp_perr = 0;
  int          seen_perr = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int model_count();
    return (model_digits.size() < D) ? model_digits.size() : D;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int val;
    if (b >= 8'h30 && b <= 8'h39) begin
      model_digits.push_back(int'(b) - 48);
      if (model_digits.size() > D) void'(model_digits.pop_front());
    end else if (b == 8'h0D || b == 8'h0A) begin
      if (model_digits.size() > 0) begin
        val = 0;
        foreach (model_digits[i]) val = val * 16 + model_digits[i];
        exp_q.push_back(16'(val));
        model_digits.delete();
      end
    end else if (b == 8'h1B) begin
      model_digits.delete();
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    @(negedge clk);
    usb_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      usb_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    usb_rx = (^b) ^ par_flip;
    repeat (CPB) @(negedge clk);
`else
    if (par_flip) usb_rx = 1'b1;
`endif
    usb_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    usb_rx = 1'b1;
    repeat (4 + $urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] b);
    model_byte(b);
    send_frame(b, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("digit_count", int'(digit_count), model_count());
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  initial begin
    logic [7:0] others[4];
    logic [7:0] b;
    int         r;
    int         waited;
    others[0] = 8'h78; others[1] = 8'h41; others[2] = 8'h20; others[3] = 8'h7E;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (load) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_load: got number 0x%0h, no load expected at %0t", number, $time);
            end else begin
              check("number", int'(number), int'(exp_q.pop_front()));
            end
            if (framing_error || parity_error) begin
              checks++;
              errors++;
              $display("FAIL pulse_overlap: load with error pulse at %0t", $time);
            end
          end
          if (framing_error) seen_ferr++;
          if (parity_error) seen_perr++;
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_number", int'(number), 0);
    check("reset_load", int'(load), 0);
    check("reset_digit_count", int'(digit_count), 0);
    check("reset_framing_error", int'(framing_error), 0);
    check("reset_parity_error", int'(parity_error), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_str("1234\r");
    send_str("42\r\n");
    send_str("123456\r");
    send_char("1"); send_char("2"); send_char(8'h1B); send_str("9\r");
    send_str("7x8\r");

    // Framing error on a digit leaves the buffer alone
    send_char("3");
    exp_ferr++;
    send_frame("5", 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("digit_count_after_ferr", int'(digit_count), model_count());
    send_str("\r");

    // Short low glitch: no frame
    @(negedge clk);
    usb_rx = 1'b0;
    repeat (3) @(negedge clk);
    usb_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("digit_count_after_glitch", int'(digit_count), model_count());

    // Reset in the middle of '5' (0x35: LSB-first 1,0,1,...)
    send_char("8");
    @(negedge clk);
    usb_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    usb_rx = 1'b1; repeat (CPB) @(negedge clk);
    usb_rx = 1'b0; repeat (CPB) @(negedge clk);
    usb_rx = 1'b1; repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    model_digits.delete();
    repeat (3) @(negedge clk);
    check("midbyte_reset_number", int'(number), 0);
    check("midbyte_reset_digit_count", int'(digit_count), 0);
    rst = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    send_str("6\r");

`ifdef UART_PARITY_EN
    send_char("2");
    exp_perr++;
    send_frame("1", 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("digit_count_after_perr", int'(digit_count), model_count());
    send_str("\r");
`endif

    // Randomised byte stream
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      b = 8'(8'h30 + $urandom_range(0, 9));
      else if (r == 6) b = 8'h0D;
      else if (r == 7) b = 8'h0A;
      else if (r == 8) b = 8'h1B;
      else             b = others[$urandom_range(0, 3)];
      send_char(b);
    end
    send_str("5\r");

    waited = 0;
    while (exp_q.size() > 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("pending_loads", exp_q.size(), 0);
    check("framing_error_count", seen_ferr, exp_ferr);
    check("parity_error_count", seen_perr, exp_perr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
